// File: rtl/btn_event_queue.sv
// Per-button pulse latch, round-robin arbiter and event FIFO. It sits between
// the button debouncers and the game/menu consumer.
module btn_event_queue #(
  parameter  int N_BTN = 4,
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(N_BTN),
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] pulse_in,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_code,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_count,
  output logic             coalesced,
  input  logic             clr_coalesced
);

  logic [N_BTN-1:0] pending_reg, pending_next;
  logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [IDX_W-1:0] code_reg, code_next;
  logic             coalesced_reg, coalesced_next;
  logic [IDX_W-1:0] mem [DEPTH];

  logic             pop, can_push;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic [N_BTN-1:0] grant_vec;
  logic [N_BTN-1:0] merge_vec;

  assign evt_valid = (count_reg != '0);
  assign evt_code  = code_reg;
  assign evt_count = count_reg;
  assign coalesced = coalesced_reg;

  assign pop      = evt_valid & evt_ready;
  assign can_push = (count_reg < CNT_W'(DEPTH)) | pop;

  // Search pending bits starting at rr_ptr, wrapping modulo N_BTN.
  always_comb begin
    logic [IDX_W:0]   cand;
    logic [IDX_W-1:0] cand_idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    cand_idx    = '0;
    for (int k = 0; k < N_BTN; k++) begin
      cand = {1'b0, rr_ptr_reg} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_BTN)) begin
        cand = cand - (IDX_W+1)'(N_BTN);
      end
      cand_idx = cand[IDX_W-1:0];
      if (!grant_valid && can_push && pending_reg[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // A pulse on a bit granted this cycle starts a fresh request; a pulse on a
  // still-waiting bit is merged and flagged.
  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      assign grant_vec[gi]    = grant_valid && (grant_idx == IDX_W'(gi));
      assign merge_vec[gi]    = pulse_in[gi] & pending_reg[gi] & ~grant_vec[gi];
      assign pending_next[gi] = (pending_reg[gi] & ~grant_vec[gi]) | pulse_in[gi];
    end
  endgenerate

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_valid) begin
      rr_ptr_next = (grant_idx == IDX_W'(N_BTN-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_comb begin
    coalesced_next = coalesced_reg;
    if (|merge_vec) begin
      coalesced_next = 1'b1;
    end else if (clr_coalesced) begin
      coalesced_next = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_next = grant_valid ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    rd_ptr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    count_next  = count_reg;
    if (grant_valid && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (!grant_valid && pop) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Registered head: forward the pushed code when it lands at the new head.
  always_comb begin
    code_next = code_reg;
    if (count_next != '0) begin
      if (grant_valid && (wr_ptr_reg == rd_ptr_next)) begin
        code_next = grant_idx;
      end else begin
        code_next = mem[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant_valid) begin
      mem[wr_ptr_reg] <= grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg   <= '0;
      rr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      code_reg      <= '0;
      coalesced_reg <= 1'b0;
    end else begin
      pending_reg   <= pending_next;
      rr_ptr_reg    <= rr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
      count_reg     <= count_next;
      code_reg      <= code_next;
      coalesced_reg <= coalesced_next;
    end
  end

endmodule

// File: tb/tb_btn_event_queue.sv
// Randomized and directed bench for btn_event_queue; a queue-based model of
// the button latches, round-robin pick and event FIFO predicts every output.
module tb_btn_event_queue;
  localparam int N_BTN = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] pulse_in = '0;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready = 1'b0;
  logic [3:0] evt_count;
  logic       coalesced;
  logic       clr_coalesced = 1'b0;

  int total = 0;
  int bad   = 0;

  // reference state
  int q[$];
  bit [N_BTN-1:0] m_pend;
  int m_rr;
  bit m_coal;

  btn_event_queue #(.N_BTN(N_BTN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pulse_in(pulse_in),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
    .evt_count(evt_count), .coalesced(coalesced), .clr_coalesced(clr_coalesced)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit [3:0] p, input bit r, input bit c, input bit rst);
    bit pop, canp, setc;
    int g;
    if (rst) begin
      q.delete();
      m_pend = '0;
      m_rr   = 0;
      m_coal = 0;
      return;
    end
    pop  = (q.size() > 0) && r;
    canp = (q.size() < DEPTH) || pop;
    g = -1;
    if (canp) begin
      for (int k = 0; k < N_BTN; k++) begin
        int idx;
        idx = (m_rr + k) % N_BTN;
        if (g < 0 && m_pend[idx]) g = idx;
      end
    end
    if (pop) void'(q.pop_front());
    if (g >= 0) begin
      q.push_back(g);
      m_rr = (g + 1) % N_BTN;
    end
    setc = 0;
    for (int i = 0; i < N_BTN; i++)
      if (p[i] && m_pend[i] && i != g) setc = 1;
    for (int i = 0; i < N_BTN; i++)
      m_pend[i] = (m_pend[i] && i != g) || p[i];
    if (setc) m_coal = 1;
    else if (c) m_coal = 0;
  endtask

  // One clock: drive inputs, advance the model at the edge, compare at negedge.
  task automatic cycle(input bit [3:0] p, input bit r, input bit c, input bit rst);
    pulse_in = p; evt_ready = r; clr_coalesced = c; reset = rst;
    @(posedge clk);
    model_edge(p, r, c, rst);
    @(negedge clk);
    check("valid", int'(evt_valid), int'(q.size() != 0));
    check("count", int'(evt_count), q.size());
    if (q.size() != 0) check("code", int'(evt_code), q[0]);
    check("coal", int'(coalesced), int'(m_coal));
    if (rst) check("rst_code", int'(evt_code), 0);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cycle(4'b0000, r, 1'b0, 1'b0);
  endtask

  initial begin
    cycle(4'b0000, 0, 0, 1);
    cycle(4'b0000, 0, 0, 1);

    // single press, held, then consumed
    cycle(4'b0100, 0, 0, 0);
    idle(6, 0);
    check("t1_code", int'(evt_code), 2);
    check("t1_count", int'(evt_count), 1);
    cycle(4'b0000, 1, 0, 0);
    check("t1_empty", int'(evt_valid), 0);

    // round-robin order 0,1,2,3 then 0,3
    cycle(4'b0000, 0, 0, 1);
    cycle(4'b1111, 0, 0, 0);
    idle(4, 0);
    cycle(4'b1001, 0, 0, 0);
    idle(3, 0);
    check("t2_count", int'(evt_count), 6);
    idle(8, 1);

    // fill, then back-pressure and coalesce on button 1
    cycle(4'b0000, 0, 0, 1);
    for (int i = 0; i < 8; i++) cycle(4'b0001, 0, 0, 0);
    idle(2, 0);
    check("t3_full", int'(evt_count), 8);
    cycle(4'b0010, 0, 0, 0);
    cycle(4'b0010, 0, 0, 0);
    check("t3_coal", int'(coalesced), 1);
    cycle(4'b0000, 1, 0, 0);
    check("t3_still_full", int'(evt_count), 8);
    cycle(4'b0000, 0, 1, 0);
    check("t3_clr", int'(coalesced), 0);
    idle(12, 1);

    // streaming at one event per cycle, pointer wrap
    for (int i = 0; i < 24; i++) cycle(4'b0001 << (i % 4), 1, 0, 0);
    idle(3, 1);

    // reset discards queued and pending events
    cycle(4'b0001, 0, 0, 0);
    cycle(4'b0010, 0, 0, 0);
    cycle(4'b1000, 0, 0, 0);
    idle(2, 0);
    cycle(4'b0100, 0, 0, 0);
    cycle(4'b0100, 0, 0, 1);
    check("t5_count", int'(evt_count), 0);
    idle(6, 1);

    // same-button pulse on grant edge yields two events, no coalesce
    cycle(4'b0001, 0, 0, 0);
    cycle(4'b0001, 0, 0, 0);
    idle(3, 0);
    check("t6_count", int'(evt_count), 2);
    idle(4, 1);

    // randomized phases with varying consumer speed
    for (int ph = 0; ph < 30; ph++) begin
      int rdy_pct;
      int pul_pct;
      rdy_pct = $urandom_range(0, 100);
      pul_pct = $urandom_range(5, 60);
      for (int i = 0; i < 100; i++) begin
        bit [3:0] p;
        for (int b = 0; b < 4; b++) p[b] = ($urandom_range(0, 99) < pul_pct);
        cycle(p, $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 15) == 0,
              $urandom_range(0, 299) == 0);
      end
    end
    idle(20, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
